rtc_clock_mt: RTL and testbench
===============================

# rtc_clock_mt

Parametrised real-time-clock core with a BCD time-of-day counter (hh:mm:ss), a maskable alarm and NUM_TIMERS independent general-purpose timers. It runs on the slow always-on RTC clock and sits behind the APB RTC register file, which drives the update strobes. Per-source events and an OR-ed interrupt feed the wake-up controller.

## Interface
Parameters:
- NUM_TIMERS, 2: number of timer channels (1..8).
- TIMER_W, 17: timer counter and target width.
- PRESC_W, 15: second prescaler width; one second = 2^PRESC_W clk_i cycles.

Ports:
- clk_i  in  1  RTC clock (32.768 kHz nominal).
- rst_i  in  1  reset; asynchronous, active-high.
- clock_update_i  in  1  load time and prescaler.
- clock_i  in  22  {hours[21:16], minutes[15:8], seconds[7:0]} BCD load value.
- init_presc_i  in  PRESC_W  prescaler load value.
- clock_o  out  22  current BCD time.
- alarm_update_i  in  1  load alarm registers.
- alarm_enable_i  in  1  alarm enable load value.
- alarm_mask_i  in  3  {hour, min, sec}; 1 = field ignored in compare.
- alarm_clock_i  in  22  alarm BCD time.
- alarm_clock_o  out  22  stored alarm time.
- alarm_enable_o  out  1  current alarm enable.
- timer_update_i  in  NUM_TIMERS  per-channel load strobe.
- timer_enable_i  in  NUM_TIMERS  enable load value.
- timer_periodic_i  in  NUM_TIMERS  1 = periodic, 0 = one-shot.
- timer_target_i  in  NUM_TIMERS*TIMER_W  channel targets, channel 0 in LSBs.
- timer_value_o  out  NUM_TIMERS*TIMER_W  current counts.
- timer_event_o  out  NUM_TIMERS  one-cycle per-channel event.
- alarm_event_o  out  1  one-cycle alarm event.
- irq_o  out  1  OR of all event outputs.
- update_day_o  out  1  one-cycle pulse on 23:59:59 -> 00:00:00.

All outputs reset to 0.

## Operation
- Prescaler: increments every cycle; sec_tick = (presc == all-ones), presc wraps to 0. clock_update_i loads init_presc_i (priority over increment).
- Time: on sec_tick, seconds increment in BCD (low digit >=9 -> 0 with carry; seconds >= 0x59 -> 0x00 and minute carry). Minutes identical; hours wrap at >= 0x23 -> 0x00. Invalid BCD loads are not corrected, only stepped by these rules. clock_update_i overrides tick.
- update_day_o registered: asserted the cycle after the tick that wraps 23:59:59.
- Alarm: field matches when masked or equal; match = AND of fields. alarm_event_o (registered) fires when enable & match & ~match_q. match_q is cleared on alarm_update_i, so an all-masked alarm fires one cycle after arming. The event clears the enable (one-shot alarm).
- Timer channel: on timer_update_i[n], load enable, mode, target; count <= 0. When enabled and count == target: event, count <= 0, enable cleared if one-shot. Otherwise count += 1. Period = target+1 cycles. Update in the match cycle wins; no event.
- irq_o = |timer_event_o | alarm_event_o, registered together with the events.

## Timing
- Loaded values are visible on outputs the cycle after the strobe.
- Event latency: one cycle after the matching state is present on registers.
- Target 0 in periodic mode gives an event every cycle after the first.
- Reset mid-count returns everything to 0 immediately; no event is emitted.

## Configuration
- RTC_DAY_CNT_EN: when defined, adds a 16-bit binary day counter. It increments on update_day_o, wraps at 0xFFFF and is loaded by clock_update_i from an added input day_i (16 bits). It is output on day_o (16 bits). It also adds a 4th alarm mask bit and alarm_day_i (16 bits) to the alarm compare.
- When not defined, these ports and logic are absent and alarm_mask_i stays 3 bits.

## Structure
- rtc_pkg: typedef bcd_time_t (hours, minutes, seconds fields), constants BCD_SEC_MAX=0x59, BCD_HOUR_MAX=0x23, and a function bcd_inc(digit) returning the next value and carry.
- Sub-module rtc_timer_ch (counter, target, mode, event register), generated NUM_TIMERS times.

## Test plan
- PRESC_W=4; load 23:59:58 with init_presc 0 -> 0x235959 after 16 cycles, then 0x000000 with update_day_o high for exactly one cycle.
- Load 0x095959, wait one tick -> clock_o = 0x100000.
- Alarm 00:00:05, mask 0, enable -> one alarm_event_o when clock reaches 0x000005, alarm_enable_o then 0. Alarm with mask 3'b111 -> event the cycle after the update.
- Timer 0 periodic target 3 -> timer_event_o[0] every 4 cycles. Timer 1 one-shot target 2 -> a single event, then value stays 0.
- timer_update_i in the match cycle -> no event, count restarts at 0.
- Assert rst_i mid-count -> all outputs 0 next edge; no stray events after release.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types and BCD helpers for the RTC core.
package rtc_pkg;

  typedef struct packed {
    logic [5:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
  } bcd_time_t;

  localparam logic [7:0] BCD_SEC_MAX  = 8'h59;
  localparam logic [5:0] BCD_HOUR_MAX = 6'h23;

  // Returns {carry, next_digit}; any digit >= 9 rolls over to 0.
  function automatic logic [4:0] bcd_inc(input logic [3:0] digit);
    if (digit >= 4'd9) return {1'b1, 4'd0};
    else return {1'b0, digit + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_byte_inc(input logic [7:0] v);
    logic [4:0] lo;
    lo = bcd_inc(v[3:0]);
    return {v[7:4] + {3'b000, lo[4]}, lo[3:0]};
  endfunction

  function automatic logic [5:0] bcd_hour_inc(input logic [5:0] v);
    logic [4:0] lo;
    lo = bcd_inc(v[3:0]);
    return {v[5:4] + {1'b0, lo[4]}, lo[3:0]};
  endfunction

endpackage

// File: rtl/rtc_timer_ch.sv
// One general-purpose timer channel: period target+1 cycles, one-shot or periodic.
// Event is registered one cycle after count==target; no backpressure.
module rtc_timer_ch
  import rtc_pkg::*;
#(
  parameter int TIMER_W = 17
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               update_i,
  input  logic               enable_i,
  input  logic               periodic_i,
  input  logic [TIMER_W-1:0] target_i,
  output logic [TIMER_W-1:0] value_o,
  output logic               event_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d, tgt_q, tgt_d;
  logic               en_q, en_d, per_q, per_d, evt_q, evt_d;

  always_comb begin
    cnt_d = cnt_q;
    tgt_d = tgt_q;
    en_d  = en_q;
    per_d = per_q;
    evt_d = 1'b0;
    if (update_i) begin
      en_d  = enable_i;
      per_d = periodic_i;
      tgt_d = target_i;
      cnt_d = '0;
    end else if (en_q) begin
      if (cnt_q == tgt_q) begin
        evt_d = 1'b1;
        cnt_d = '0;
        if (!per_q) en_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tgt_q <= '0;
      en_q  <= 1'b0;
      per_q <= 1'b0;
      evt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
      en_q  <= en_d;
      per_q <= per_d;
      evt_q <= evt_d;
    end
  end

  assign value_o = cnt_q;
  assign event_o = evt_q;

endmodule

// File: rtl/rtc_clock_mt.sv
// RTC core: BCD time of day, one-shot maskable alarm, NUM_TIMERS timers; events one cycle after match, no backpressure.
// RTC_DAY_CNT_EN adds a 16-bit day counter (day_i/day_o) and a day field in the alarm compare.
module rtc_clock_mt
  import rtc_pkg::*;
#(
  parameter int NUM_TIMERS = 2,
  parameter int TIMER_W    = 17,
  parameter int PRESC_W    = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clock_update_i,
  input  logic [21:0]                   clock_i,
  input  logic [PRESC_W-1:0]            init_presc_i,
  output logic [21:0]                   clock_o,
  input  logic                          alarm_update_i,
  input  logic                          alarm_enable_i,
`ifdef RTC_DAY_CNT_EN
  input  logic [3:0]                    alarm_mask_i,
  input  logic [15:0]                   alarm_day_i,
  input  logic [15:0]                   day_i,
  output logic [15:0]                   day_o,
`else
  input  logic [2:0]                    alarm_mask_i,
`endif
  input  logic [21:0]                   alarm_clock_i,
  output logic [21:0]                   alarm_clock_o,
  output logic                          alarm_enable_o,
  input  logic [NUM_TIMERS-1:0]         timer_update_i,
  input  logic [NUM_TIMERS-1:0]         timer_enable_i,
  input  logic [NUM_TIMERS-1:0]         timer_periodic_i,
  input  logic [NUM_TIMERS*TIMER_W-1:0] timer_target_i,
  output logic [NUM_TIMERS*TIMER_W-1:0] timer_value_o,
  output logic [NUM_TIMERS-1:0]         timer_event_o,
  output logic                          alarm_event_o,
  output logic                          irq_o,
  output logic                          update_day_o
);

`ifdef RTC_DAY_CNT_EN
  localparam int AM_W = 4;
  logic [15:0] day_q, day_d, alarm_day_q, alarm_day_d;
`else
  localparam int AM_W = 3;
`endif

  logic [PRESC_W-1:0] presc_q, presc_d;
  bcd_time_t          clock_q, clock_d, clock_nxt, alarm_q, alarm_d;
  logic [AM_W-1:0]    mask_q, mask_d;
  logic               sec_tick, day_wrap, match;
  logic               upd_day_q, upd_day_d;
  logic               alarm_en_q, alarm_en_d, match_q, match_d, alarm_evt_q, alarm_evt_d;

  assign sec_tick = (presc_q == '1);

  // Rollover tests use >= so invalid BCD loads still converge to legal time.
  always_comb begin
    clock_nxt = clock_q;
    day_wrap  = 1'b0;
    if (clock_q.seconds >= BCD_SEC_MAX) begin
      clock_nxt.seconds = '0;
      if (clock_q.minutes >= BCD_SEC_MAX) begin
        clock_nxt.minutes = '0;
        if (clock_q.hours >= BCD_HOUR_MAX) begin
          clock_nxt.hours = '0;
          day_wrap        = 1'b1;
        end else begin
          clock_nxt.hours = bcd_hour_inc(clock_q.hours);
        end
      end else begin
        clock_nxt.minutes = bcd_byte_inc(clock_q.minutes);
      end
    end else begin
      clock_nxt.seconds = bcd_byte_inc(clock_q.seconds);
    end
  end

  always_comb begin
    presc_d   = presc_q + 1'b1;
    clock_d   = clock_q;
    upd_day_d = 1'b0;
    if (clock_update_i) begin
      presc_d = init_presc_i;
      clock_d = bcd_time_t'(clock_i);
    end else if (sec_tick) begin
      clock_d   = clock_nxt;
      upd_day_d = day_wrap;
    end
  end

  always_comb begin
    match = (mask_q[0] || clock_q.seconds == alarm_q.seconds) &&
            (mask_q[1] || clock_q.minutes == alarm_q.minutes) &&
            (mask_q[2] || clock_q.hours   == alarm_q.hours);
`ifdef RTC_DAY_CNT_EN
    match = match && (mask_q[3] || day_q == alarm_day_q);
    day_d       = update_day_o ? day_q + 16'd1 : day_q;
    alarm_day_d = alarm_day_q;
    if (clock_update_i) day_d = day_i;
    if (alarm_update_i) alarm_day_d = alarm_day_i;
`endif
    alarm_evt_d = !alarm_update_i && alarm_en_q && match && !match_q;
    alarm_en_d  = alarm_evt_d ? 1'b0 : alarm_en_q;
    alarm_d     = alarm_q;
    mask_d      = mask_q;
    match_d     = match;
    if (alarm_update_i) begin
      alarm_en_d = alarm_enable_i;
      alarm_d    = bcd_time_t'(alarm_clock_i);
      mask_d     = alarm_mask_i;
      match_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q     <= '0;
      clock_q     <= '0;
      upd_day_q   <= 1'b0;
      alarm_q     <= '0;
      mask_q      <= '0;
      alarm_en_q  <= 1'b0;
      match_q     <= 1'b0;
      alarm_evt_q <= 1'b0;
`ifdef RTC_DAY_CNT_EN
      day_q       <= '0;
      alarm_day_q <= '0;
`endif
    end else begin
      presc_q     <= presc_d;
      clock_q     <= clock_d;
      upd_day_q   <= upd_day_d;
      alarm_q     <= alarm_d;
      mask_q      <= mask_d;
      alarm_en_q  <= alarm_en_d;
      match_q     <= match_d;
      alarm_evt_q <= alarm_evt_d;
`ifdef RTC_DAY_CNT_EN
      day_q       <= day_d;
      alarm_day_q <= alarm_day_d;
`endif
    end
  end

  for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_tmr
    rtc_timer_ch #(.TIMER_W(TIMER_W)) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .update_i   (timer_update_i[n]),
      .enable_i   (timer_enable_i[n]),
      .periodic_i (timer_periodic_i[n]),
      .target_i   (timer_target_i[n*TIMER_W +: TIMER_W]),
      .value_o    (timer_value_o[n*TIMER_W +: TIMER_W]),
      .event_o    (timer_event_o[n])
    );
  end

  assign clock_o        = clock_q;
  assign alarm_clock_o  = alarm_q;
  assign alarm_enable_o = alarm_en_q;
  assign alarm_event_o  = alarm_evt_q;
  assign update_day_o   = upd_day_q;
  // Pure OR of event flops, so irq shares the event cycle exactly.
  assign irq_o          = |timer_event_o | alarm_evt_q;
`ifdef RTC_DAY_CNT_EN
  assign day_o          = day_q;
`endif

endmodule

// File: tb/tb_rtc_clock_mt.sv
// Directed bench for rtc_clock_mt with PRESC_W=4 (one second = 16 cycles).
module tb_rtc_clock_mt;
  localparam int NT = 2;
  localparam int TW = 17;
  localparam int PW = 4;

  logic          clk_i = 0, rst_i = 1;
  logic          clock_update_i = 0;
  logic [21:0]   clock_i = '0;
  logic [PW-1:0] init_presc_i = '0;
  logic [21:0]   clock_o;
  logic          alarm_update_i = 0, alarm_enable_i = 0;
  logic [2:0]    alarm_mask_i = '0;
  logic [21:0]   alarm_clock_i = '0, alarm_clock_o;
  logic          alarm_enable_o;
  logic [NT-1:0] timer_update_i = '0, timer_enable_i = '0, timer_periodic_i = '0;
  logic [NT*TW-1:0] timer_target_i = '0, timer_value_o;
  logic [NT-1:0] timer_event_o;
  logic          alarm_event_o, irq_o, update_day_o;

  int checks = 0, failures = 0;

  rtc_clock_mt #(.NUM_TIMERS(NT), .TIMER_W(TW), .PRESC_W(PW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .clock_update_i(clock_update_i), .clock_i(clock_i), .init_presc_i(init_presc_i),
    .clock_o(clock_o),
    .alarm_update_i(alarm_update_i), .alarm_enable_i(alarm_enable_i),
    .alarm_mask_i(alarm_mask_i), .alarm_clock_i(alarm_clock_i),
    .alarm_clock_o(alarm_clock_o), .alarm_enable_o(alarm_enable_o),
    .timer_update_i(timer_update_i), .timer_enable_i(timer_enable_i),
    .timer_periodic_i(timer_periodic_i), .timer_target_i(timer_target_i),
    .timer_value_o(timer_value_o), .timer_event_o(timer_event_o),
    .alarm_event_o(alarm_event_o), .irq_o(irq_o), .update_day_o(update_day_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {clock_o, alarm_clock_o, alarm_enable_o, timer_event_o, alarm_event_o,
            irq_o, update_day_o} | 64'(timer_value_o);
  endfunction

  typedef struct {
    logic [21:0] load;
    logic [21:0] exp;
    logic        day;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{22'h000000, 22'h000001, 1'b0};
    vecs[1] = '{22'h000009, 22'h000010, 1'b0};
    vecs[2] = '{22'h000059, 22'h000100, 1'b0};
    vecs[3] = '{22'h095959, 22'h100000, 1'b0};
    vecs[4] = '{22'h195959, 22'h200000, 1'b0};
    vecs[5] = '{22'h235959, 22'h000000, 1'b1};
    vecs[6] = '{22'h125930, 22'h125931, 1'b0};
    vecs[7] = '{22'h00005A, 22'h000100, 1'b0};
    vecs[8] = '{22'h00003A, 22'h000040, 1'b0};
    vecs[9] = '{22'h220959, 22'h221000, 1'b0};

    step();
    check("reset_outputs", all_outs(), 64'd0);
    rst_i = 0;
    step();

    // Single-tick BCD stepping: init_presc all-ones makes the next cycle a tick.
    foreach (vecs[i]) begin
      clock_update_i = 1; clock_i = vecs[i].load; init_presc_i = '1;
      step();
      clock_update_i = 0;
      check($sformatf("load_%0d", i), clock_o, vecs[i].load);
      check($sformatf("load_day_%0d", i), update_day_o, 1'b0);
      step();
      check($sformatf("tick_%0d", i), clock_o, vecs[i].exp);
      check($sformatf("tick_day_%0d", i), update_day_o, vecs[i].day);
    end

    // Full day rollover from 23:59:58 with prescaler starting at 0.
    clock_update_i = 1; clock_i = 22'h235958; init_presc_i = '0;
    step();
    clock_update_i = 0;
    repeat (15) step();
    check("pre_tick_hold", clock_o, 22'h235958);
    step();
    check("sec_235959", clock_o, 22'h235959);
    check("no_day_yet", update_day_o, 1'b0);
    repeat (16) step();
    check("wrap_000000", clock_o, 22'h000000);
    check("day_pulse", update_day_o, 1'b1);
    step();
    check("day_pulse_one_cycle", update_day_o, 1'b0);

    // Alarm at 00:00:05, all fields compared.
    clock_update_i = 1; clock_i = 22'h000004; init_presc_i = '1;
    alarm_update_i = 1; alarm_enable_i = 1; alarm_mask_i = 3'b000; alarm_clock_i = 22'h000005;
    step();
    clock_update_i = 0; alarm_update_i = 0;
    check("alarm_clock_o", alarm_clock_o, 22'h000005);
    check("alarm_en_armed", alarm_enable_o, 1'b1);
    check("alarm_no_early", alarm_event_o, 1'b0);
    step();
    check("alarm_time_hit", clock_o, 22'h000005);
    check("alarm_latency", alarm_event_o, 1'b0);
    step();
    check("alarm_event", alarm_event_o, 1'b1);
    check("alarm_irq", irq_o, 1'b1);
    check("alarm_en_cleared", alarm_enable_o, 1'b0);
    begin
      int extra = 0;
      for (int k = 0; k < 20; k++) begin
        step();
        extra += int'(alarm_event_o);
      end
      check("alarm_single", extra, 0);
    end

    // Fully masked alarm fires right after arming.
    alarm_update_i = 1; alarm_enable_i = 1; alarm_mask_i = 3'b111;
    step();
    alarm_update_i = 0;
    check("masked_not_yet", alarm_event_o, 1'b0);
    step();
    check("masked_fire", alarm_event_o, 1'b1);
    step();
    check("masked_once", alarm_event_o, 1'b0);
    check("masked_en_clr", alarm_enable_o, 1'b0);

    // Timer 0 periodic target 3, timer 1 one-shot target 2.
    timer_update_i = 2'b11; timer_enable_i = 2'b11; timer_periodic_i = 2'b01;
    timer_target_i = {17'd2, 17'd3};
    step();
    timer_update_i = '0;
    check("t0_start", timer_value_o[TW-1:0], 17'd0);
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("t0_evt_%0d", k), timer_event_o[0], (k % 4) == 0);
      check($sformatf("t1_evt_%0d", k), timer_event_o[1], k == 3);
      check($sformatf("irq_%0d", k), irq_o, ((k % 4) == 0) || (k == 3));
      if (k >= 3) check($sformatf("t1_val_%0d", k), timer_value_o[2*TW-1:TW], 17'd0);
      else check($sformatf("t1_val_%0d", k), timer_value_o[2*TW-1:TW], 17'(k));
    end

    // Reload in the match cycle: no event, count restarts.
    repeat (3) step();
    check("t0_at_target", timer_value_o[TW-1:0], 17'd3);
    timer_update_i = 2'b01;
    step();
    timer_update_i = '0;
    check("t0_upd_no_evt", timer_event_o[0], 1'b0);
    check("t0_upd_cnt0", timer_value_o[TW-1:0], 17'd0);
    step();
    check("t0_upd_cnt1", timer_value_o[TW-1:0], 17'd1);

    // Asynchronous reset mid-count.
    #3 rst_i = 1;
    #1 check("rst_async", all_outs(), 64'd0);
    step();
    check("rst_edge", all_outs(), 64'd0);
    rst_i = 0;
    begin
      int stray = 0;
      for (int k = 0; k < 20; k++) begin
        step();
        stray += int'(|timer_event_o) + int'(alarm_event_o) + int'(irq_o);
      end
      check("no_stray_events", stray, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
